// File: rtl/clk_rst_seq_pkg.sv
// Shared types and default timing for the clock/reset bring-up sequencer.
// One-hot state encoding keeps state decode shallow and makes illegal states easy to detect.
package clk_rst_seq_pkg;

    typedef enum logic [5:0] {
        S_SETTLE = 6'b000001,
        S_CLKEN  = 6'b000010,
        S_REL    = 6'b000100,
        S_DONE   = 6'b001000,
        S_HOLD   = 6'b010000,
        S_GATE   = 6'b100000
    } seq_state_t;

    localparam int DEF_NUM_DOM     = 4;
    localparam int DEF_SETTLE_CYC  = 16;
    localparam int DEF_EN2RST_CYC  = 8;
    localparam int DEF_STAGGER_CYC = 4;
    localparam int DEF_HOLD_CYC    = 8;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/clk_rst_sequencer_if.sv
// Request/mask inputs and per-domain clock-enable/reset outputs of the sequencer.
// master = the side requesting sequences, slave = the sequencer itself.
interface clk_rst_sequencer_if #(
    parameter int NUM_DOM = 4
);
    logic               seq_req;
    logic [NUM_DOM-1:0] dom_mask;
    logic [NUM_DOM-1:0] clk_en;
    logic [NUM_DOM-1:0] dom_rst_n;
    logic               seq_busy;
    logic               seq_done;

    modport master (
        output seq_req, dom_mask,
        input  clk_en, dom_rst_n, seq_busy, seq_done
    );

    modport slave (
        input  seq_req, dom_mask,
        output clk_en, dom_rst_n, seq_busy, seq_done
    );
endinterface

// File: rtl/seq_dly_cnt.sv
// Purpose: loadable down counter that parks at zero and flags expiry.
// Latency: load takes effect on the next edge; expired is decoded from the register.
// Backpressure: none, free-running once loaded.
module seq_dly_cnt #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/clk_rst_sequencer.sv
// Purpose: gate clocks, open enables, then release domain resets one by one; re-runs on seq_req.
// Latency: all outputs registered; defaults give enables at edge 16, releases 24..36, done at 40.
// Backpressure: seq_req is only honoured in S_DONE; requests while busy are dropped, not queued.
module clk_rst_sequencer
    import clk_rst_seq_pkg::*;
#(
    parameter int NUM_DOM     = DEF_NUM_DOM,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int EN2RST_CYC  = DEF_EN2RST_CYC,
    parameter int STAGGER_CYC = DEF_STAGGER_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clk_rst_sequencer_if.slave   sif
);

    localparam int IDX_W = $clog2(NUM_DOM + 1);

    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] EN2RST_LD  = CNT_W'(EN2RST_CYC - 1);
    localparam logic [CNT_W-1:0] STAGGER_LD = CNT_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);

    if (NUM_DOM < 1 || NUM_DOM > 16) begin : g_bad_dom
        $error("NUM_DOM out of range 1..16");
    end
    if (SETTLE_CYC < 1 || EN2RST_CYC < 1 || STAGGER_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cyc
        $error("all *_CYC parameters must be >= 1");
    end
    if (CNT_W < 32 && (SETTLE_CYC > (1 << CNT_W) || EN2RST_CYC > (1 << CNT_W) ||
                       STAGGER_CYC > (1 << CNT_W) || HOLD_CYC > (1 << CNT_W))) begin : g_bad_w
        $error("a *_CYC parameter does not fit the delay counter");
    end

    seq_state_t         state_q, state_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [NUM_DOM-1:0] mask_q, mask_nxt;
    logic [NUM_DOM-1:0] clk_en_q, clk_en_nxt;
    logic [NUM_DOM-1:0] rst_n_q, rst_n_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_exp;

    seq_dly_cnt #(
        .CNT_W   (CNT_W),
        .RST_VAL (SETTLE_LD)
    ) u_dly_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .expired  (cnt_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_SETTLE;
            idx_q    <= '0;
            mask_q   <= '0;
            clk_en_q <= '0;
            rst_n_q  <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            idx_q    <= idx_nxt;
            mask_q   <= mask_nxt;
            clk_en_q <= clk_en_nxt;
            rst_n_q  <= rst_n_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        idx_nxt    = idx_q;
        mask_nxt   = mask_q;
        clk_en_nxt = clk_en_q;
        rst_n_nxt  = rst_n_q;
        busy_nxt   = busy_q;
        done_nxt   = done_q;
        cnt_load   = 1'b0;
        cnt_val    = '0;

        unique case (state_q)
            S_SETTLE: begin
                if (cnt_exp) begin
                    state_nxt  = S_CLKEN;
                    clk_en_nxt = ~mask_q;
                    cnt_load   = 1'b1;
                    cnt_val    = EN2RST_LD;
                end
            end
            S_CLKEN: begin
                if (cnt_exp) begin
                    state_nxt    = S_REL;
                    rst_n_nxt[0] = ~mask_q[0];
                    idx_nxt      = IDX_W'(1);
                    cnt_load     = 1'b1;
                    cnt_val      = STAGGER_LD;
                end
            end
            S_REL: begin
                // Masked domains still burn their slot so release timing ignores the mask.
                if (cnt_exp) begin
                    if (idx_q == IDX_W'(NUM_DOM)) begin
                        state_nxt = S_DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_DOM; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                rst_n_nxt[i] = ~mask_q[i];
                            end
                        end
                        idx_nxt  = idx_q + IDX_W'(1);
                        cnt_load = 1'b1;
                        cnt_val  = STAGGER_LD;
                    end
                end
            end
            S_DONE: begin
                if (sif.seq_req) begin
                    state_nxt = S_HOLD;
                    mask_nxt  = sif.dom_mask;
                    rst_n_nxt = '0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    cnt_load  = 1'b1;
                    cnt_val   = HOLD_LD;
                end
            end
            S_HOLD: begin
                if (cnt_exp) begin
                    state_nxt  = S_GATE;
                    clk_en_nxt = '0;
                    cnt_load   = 1'b1;
                    cnt_val    = SETTLE_LD;
                end
            end
            S_GATE: begin
                if (cnt_exp) begin
                    state_nxt  = S_CLKEN;
                    clk_en_nxt = ~mask_q;
                    cnt_load   = 1'b1;
                    cnt_val    = EN2RST_LD;
                end
            end
            default: begin
                state_nxt = S_SETTLE;
                cnt_load  = 1'b1;
                cnt_val   = SETTLE_LD;
            end
        endcase
    end

    assign sif.clk_en    = clk_en_q;
    assign sif.dom_rst_n = rst_n_q;
    assign sif.seq_busy  = busy_q;
    assign sif.seq_done  = done_q;

    a_state_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(state_q));
    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) done_q |-> !busy_q);
    a_rst_needs_clk: assert property (@(posedge clk) disable iff (!rst_n) (rst_n_q & ~clk_en_q) == '0);

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Randomized bench: default-parameter DUT plus a NUM_DOM=1/all-CYC=1 DUT, both checked each
// cycle against a timeline model that derives outputs from cycles elapsed since sequence start.
module tb_clk_rst_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clk_rst_sequencer_if #(.NUM_DOM(4)) sif_a ();
    clk_rst_sequencer_if #(.NUM_DOM(1)) sif_b ();

    assign sif_b.seq_req  = sif_a.seq_req;
    assign sif_b.dom_mask = sif_a.dom_mask[0];

    clk_rst_sequencer #(
        .NUM_DOM(4), .SETTLE_CYC(16), .EN2RST_CYC(8), .STAGGER_CYC(4), .HOLD_CYC(8), .CNT_W(16)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif_a.slave)
    );

    clk_rst_sequencer #(
        .NUM_DOM(1), .SETTLE_CYC(1), .EN2RST_CYC(1), .STAGGER_CYC(1), .HOLD_CYC(1), .CNT_W(16)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif_b.slave)
    );

    int err_cnt = 0;
    int chk_cnt = 0;
    int n = 0;

    // Model state per DUT: start edge of current sequence, re-sequence flag, masks, done.
    int          a_r, b_r;
    bit          a_rs, b_rs;
    logic [15:0] a_mask, a_prev, b_mask, b_prev;
    logic        a_done, b_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s @edge %0d: got %0h want %0h", tag, n, obs, exp);
        end
    endtask

    function automatic void ref_out(input int k, input bit reseq, input int s, input int e,
                                    input int g, input int h, input int nd,
                                    input logic [15:0] mask, input logic [15:0] prev,
                                    output logic [15:0] en, output logic [15:0] rn,
                                    output logic done);
        int base;
        logic [15:0] keep;
        base = reseq ? h : 0;
        keep = 16'((32'd1 << nd) - 1);
        en   = '0;
        rn   = '0;
        if (reseq && k < h) en = ~prev;
        else if (k >= base + s) en = ~mask;
        en = en & keep;
        for (int i = 0; i < nd; i++)
            if (k >= base + s + e + i * g) rn[i] = ~mask[i];
        done = (k >= base + s + e + nd * g);
    endfunction

    task automatic model_reset();
        n = 0;
        a_r = 0; a_rs = 0; a_mask = '0; a_prev = '0; a_done = 1'b0;
        b_r = 0; b_rs = 0; b_mask = '0; b_prev = '0; b_done = 1'b0;
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_a_en"},   {28'b0, sif_a.clk_en},    32'h0);
        chk({tag, "_a_rstn"}, {28'b0, sif_a.dom_rst_n}, 32'h0);
        chk({tag, "_a_busy"}, {31'b0, sif_a.seq_busy},  32'h1);
        chk({tag, "_a_done"}, {31'b0, sif_a.seq_done},  32'h0);
        chk({tag, "_b_en"},   {31'b0, sif_b.clk_en},    32'h0);
        chk({tag, "_b_rstn"}, {31'b0, sif_b.dom_rst_n}, 32'h0);
        chk({tag, "_b_busy"}, {31'b0, sif_b.seq_busy},  32'h1);
        chk({tag, "_b_done"}, {31'b0, sif_b.seq_done},  32'h0);
    endtask

    // One rising edge: advance the model with the inputs that were sampled, then compare.
    task automatic step();
        logic [15:0] en, rn;
        logic        dn;
        @(posedge clk);
        #1;
        n++;
        if (a_done && sif_a.seq_req) begin
            a_r = n; a_rs = 1'b1; a_prev = a_mask; a_mask = {12'b0, sif_a.dom_mask};
        end
        ref_out(n - a_r, a_rs, 16, 8, 4, 8, 4, a_mask, a_prev, en, rn, dn);
        a_done = dn;
        chk("a_clk_en",    {28'b0, sif_a.clk_en},    {28'b0, en[3:0]});
        chk("a_dom_rst_n", {28'b0, sif_a.dom_rst_n}, {28'b0, rn[3:0]});
        chk("a_seq_done",  {31'b0, sif_a.seq_done},  {31'b0, dn});
        chk("a_seq_busy",  {31'b0, sif_a.seq_busy},  {31'b0, ~dn});

        if (b_done && sif_b.seq_req) begin
            b_r = n; b_rs = 1'b1; b_prev = b_mask; b_mask = {15'b0, sif_b.dom_mask};
        end
        ref_out(n - b_r, b_rs, 1, 1, 1, 1, 1, b_mask, b_prev, en, rn, dn);
        b_done = dn;
        chk("b_clk_en",    {31'b0, sif_b.clk_en},    {31'b0, en[0]});
        chk("b_dom_rst_n", {31'b0, sif_b.dom_rst_n}, {31'b0, rn[0]});
        chk("b_seq_done",  {31'b0, sif_b.seq_done},  {31'b0, dn});
        chk("b_seq_busy",  {31'b0, sif_b.seq_busy},  {31'b0, ~dn});
    endtask

    initial begin
        rst_n         = 1'b0;
        sif_a.seq_req  = 1'b0;
        sif_a.dom_mask = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_rst_vals("por");
        rst_n = 1'b1;

        // Power-on with random requests while busy: all of them must be dropped.
        for (int i = 1; i <= 45; i++) begin
            step();
            sif_a.seq_req  = (i < 38) ? ($urandom_range(0, 2) == 0) : 1'b0;
            sif_a.dom_mask = 4'($urandom);
        end

        // Single request in S_DONE with domain 2 masked.
        sif_a.seq_req  = 1'b1;
        sif_a.dom_mask = 4'b0100;
        step();
        sif_a.seq_req = 1'b0;
        for (int i = 0; i < 55; i++) begin
            step();
            sif_a.dom_mask = 4'($urandom);
        end

        // Request held high: sequence loops back-to-back.
        sif_a.seq_req = 1'b1;
        for (int i = 0; i < 110; i++) begin
            step();
            sif_a.dom_mask = 4'($urandom);
        end

        // Sparse random requests and masks.
        for (int i = 0; i < 300; i++) begin
            sif_a.seq_req  = ($urandom_range(0, 15) == 0);
            sif_a.dom_mask = 4'($urandom);
            step();
        end
        sif_a.seq_req = 1'b0;

        // Fresh bring-up, then async reset in the middle of the release staircase.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_rst_vals("rst2");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) step();
        #3;
        rst_n = 1'b0;
        #1;
        chk_rst_vals("mid_rel");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 45; i++) step();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
